// File: rtl/alu_sequencer.sv
// Multi-cycle MUL / DIVU sequencer that borrows an external ALU for every add and subtract.
// Shift-and-add multiply and restoring divide, one bit per RUN cycle over 32 cycles.
module alu_sequencer #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             op,
   input  logic [WIDTH-1:0] opa,
   input  logic [WIDTH-1:0] opb,
   output logic [WIDTH-1:0] alu_a,
   output logic [WIDTH-1:0] alu_b,
   output logic [2:0]       alu_control,
   input  logic [WIDTH-1:0] alu_y,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] rem_out
);

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_NOP = 3'b000;
   localparam logic       OP_MUL  = 1'b0;
   localparam logic       OP_DIVU = 1'b1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   logic [4:0]       cnt;
   logic             op_r;

   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;

   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] dvd;
   logic [WIDTH-1:0] dvs;
   logic [WIDTH-1:0] quo;

   logic [WIDTH-1:0] t;
   logic             q_bit;
   logic [WIDTH-1:0] acc_nxt;
   logic [WIDTH-1:0] rem_nxt;
   logic [WIDTH-1:0] quo_nxt;

   // Partial remainder shifted left with the next dividend bit; rem[31] is the 33rd bit of that value.
   assign t       = {rem[WIDTH-2:0], dvd[WIDTH-1]};
   assign q_bit   = rem[WIDTH-1] | (t >= dvs);
   assign rem_nxt = q_bit ? alu_y : t;
   assign quo_nxt = {quo[WIDTH-2:0], q_bit};
   assign acc_nxt = mplier[0] ? alu_y : acc;

   // ALU operands come only from state registers so there is no loop through alu_y.
   always_comb begin
      alu_a       = '0;
      alu_b       = '0;
      alu_control = ALU_NOP;
      if (state == RUN) begin
         if (op_r == OP_MUL) begin
            alu_a       = acc;
            alu_b       = mcand;
            alu_control = ALU_ADD;
         end else begin
            alu_a       = t;
            alu_b       = dvs;
            alu_control = ALU_SUB;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         op_r    <= 1'b0;
         acc     <= '0;
         mcand   <= '0;
         mplier  <= '0;
         rem     <= '0;
         dvd     <= '0;
         dvs     <= '0;
         quo     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         result  <= '0;
         rem_out <= '0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  op_r   <= op;
                  cnt    <= '0;
                  acc    <= '0;
                  mcand  <= opa;
                  mplier <= opb;
                  rem    <= '0;
                  dvd    <= opa;
                  dvs    <= opb;
                  quo    <= '0;
                  if (op == OP_DIVU && opb == '0) begin
                     // Divide by zero finishes immediately with all-ones quotient.
                     state   <= DONE;
                     done    <= 1'b1;
                     result  <= '1;
                     rem_out <= opa;
                  end else begin
                     state <= RUN;
                     busy  <= 1'b1;
                  end
               end
            end

            RUN: begin
               cnt <= cnt + 5'd1;
               if (op_r == OP_MUL) begin
                  acc    <= acc_nxt;
                  mcand  <= mcand << 1;
                  mplier <= mplier >> 1;
               end else begin
                  rem <= rem_nxt;
                  dvd <= dvd << 1;
                  quo <= quo_nxt;
               end
               if (cnt == 5'd31) begin
                  state   <= DONE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  result  <= (op_r == OP_MUL) ? acc_nxt : quo_nxt;
                  rem_out <= (op_r == OP_MUL) ? '0 : rem_nxt;
               end
            end

            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end

            default: begin
               state <= IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: driver pushes expected results, negedge monitor pops and compares.
// The ALU itself is modelled here as a plain combinational add/sub/and/or unit.
module tb_alu_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        op = 1'b0;
   logic [31:0] opa = '0;
   logic [31:0] opb = '0;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [2:0]  alu_control;
   logic [31:0] alu_y;
   logic        busy;
   logic        done;
   logic [31:0] result;
   logic [31:0] rem_out;

   always #5 clk = ~clk;

   alu_sequencer #(.WIDTH(32)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .opa(opa), .opb(opb),
      .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control), .alu_y(alu_y),
      .busy(busy), .done(done), .result(result), .rem_out(rem_out)
   );

   always_comb begin
      case (alu_control)
         3'b010:  alu_y = alu_a + alu_b;
         3'b110:  alu_y = alu_a - alu_b;
         3'b000:  alu_y = alu_a & alu_b;
         3'b001:  alu_y = alu_a | alu_b;
         default: alu_y = '0;
      endcase
   end

   typedef struct {
      int unsigned due;
      logic [31:0] res;
      logic [31:0] rem;
      int unsigned busy_n;
   } exp_t;

   exp_t        exp_q[$];
   int unsigned cyc = 0;
   logic        rst_seen = 1'b0;
   int          errors = 0;
   int          checks = 0;
   int unsigned busy_n = 0;
   logic [31:0] held_res = '0;
   logic [31:0] held_rem = '0;

   always @(posedge clk) begin
      cyc      <= cyc + 1;
      rst_seen <= reset;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   // Monitor
   always @(negedge clk) begin
      exp_t e;
      logic exp_done;
      if (rst_seen) begin
         exp_q.delete();
         held_res = '0;
         held_rem = '0;
         busy_n   = 0;
      end else begin
         while (exp_q.size() != 0 && exp_q[0].due < cyc) void'(exp_q.pop_front());
         exp_done = (exp_q.size() != 0) && (exp_q[0].due == cyc);
         chk("done", {31'b0, done}, {31'b0, exp_done});
         if (!busy) begin
            chk("alu_a_idle", alu_a, 32'd0);
            chk("alu_b_idle", alu_b, 32'd0);
            chk("alu_ctl_idle", {29'b0, alu_control}, 32'd0);
         end else begin
            busy_n++;
         end
         if (done && exp_done) begin
            e = exp_q.pop_front();
            chk("result", result, e.res);
            chk("rem_out", rem_out, e.rem);
            chk("busy_cycles", busy_n, e.busy_n);
            held_res = e.res;
            held_rem = e.rem;
            busy_n   = 0;
         end else if (!done) begin
            chk("result_held", result, held_res);
            chk("rem_held", rem_out, held_rem);
         end
      end
   end

   // Issue one operation; noise_k>0 pulses a stray start at that wait step.
   task automatic issue(input logic o, input logic [31:0] a, input logic [31:0] b, input int noise_k);
      exp_t e;
      int   lat;
      if (o && b == 0) begin
         e.res = 32'hFFFF_FFFF; e.rem = a; lat = 1;
      end else if (o) begin
         e.res = a / b; e.rem = a % b; lat = 33;
      end else begin
         e.res = a * b; e.rem = 32'd0; lat = 33;
      end
      e.busy_n = (lat == 33) ? 32 : 0;
      e.due    = cyc + lat;
      exp_q.push_back(e);
      op = o; opa = a; opb = b; start = 1'b1;
      @(negedge clk);
      start = 1'b0; opa = $urandom; opb = $urandom;
      for (int k = 1; k <= lat; k++) begin
         @(negedge clk);
         start = (k == noise_k);
         if (k == noise_k) begin
            op = ~o; opa = $urandom; opb = $urandom_range(1, 9);
         end
      end
   endtask

   initial begin
      exp_t e;
      int unsigned e0;
      logic [31:0] a, b;
      logic        o;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_done", {31'b0, done}, 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_rem", rem_out, 32'd0);
      @(negedge clk);

      issue(1'b0, 32'd7, 32'd6, 0);
      issue(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      issue(1'b1, 32'd100, 32'd7, 5);
      issue(1'b1, 32'hFFFF_FFFF, 32'h8000_0000, 32);
      issue(1'b1, 32'd55, 32'd0, 0);
      issue(1'b0, 32'd0, 32'd12345, 0);
      issue(1'b0, 32'd9, 32'd0, 0);
      issue(1'b1, 32'd0, 32'd3, 0);
      issue(1'b1, 32'd5, 32'd9, 0);

      // Reset in the middle of a multiply aborts it without a done pulse.
      e0 = cyc;
      op = 1'b0; opa = 32'd3; opb = 32'd5; start = 1'b1;
      e.due = e0 + 33; e.res = 32'd15; e.rem = 32'd0; e.busy_n = 32;
      exp_q.push_back(e);
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort_busy", {31'b0, busy}, 32'd0);
      chk("abort_done", {31'b0, done}, 32'd0);
      chk("abort_result", result, 32'd0);
      chk("abort_rem", rem_out, 32'd0);
      @(negedge clk);
      issue(1'b0, 32'd3, 32'd5, 0);

      // Start coincident with reset is dropped.
      reset = 1'b1; start = 1'b1; op = 1'b0; opa = 32'd3; opb = 32'd5;
      @(negedge clk);
      reset = 1'b0; start = 1'b0;
      @(negedge clk);
      chk("rst_start_busy", {31'b0, busy}, 32'd0);
      repeat (3) @(negedge clk);

      // Start held high: one accept per IDLE visit.
      e0 = cyc;
      for (int i = 0; i < 3; i++) begin
         e.due = e0 + 33 + 34 * i; e.res = 32'd4; e.rem = 32'd1; e.busy_n = 32;
         exp_q.push_back(e);
      end
      op = 1'b1; opa = 32'd9; opb = 32'd2; start = 1'b1;
      repeat (101) @(negedge clk);
      start = 1'b0;
      @(negedge clk);

      for (int n = 0; n < 16; n++) begin
         o = 1'(($urandom >> 3) & 1);
         a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 200)) : $urandom;
         case ($urandom_range(0, 5))
            0:       b = 32'd0;
            1:       b = 32'($urandom_range(1, 15));
            default: b = $urandom;
         endcase
         issue(o, a, b, (n % 4 == 1) ? 10 : 0);
      end

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
